hs_rr_arbiter: RTL

Round-robin arbiter sharing one valid/ready output channel among N_REQ valid/ready requesters. It sits between several producers in the handshake-protocol datapath and the single downstream consumer. It picks at most one requester per cycle and registers the winning beat in a one-entry output stage. It also counts completed output beats on a 3-bit wrap-around counter.

---
 rtl/hs_rr_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin arbiter merging N_REQ valid/ready producers onto
// one registered valid/ready output stage, with a modulo-8 completed-beat count.
//
// state | meaning
// ------+------------------------------------------------
// EMPTY | output stage holds no beat, out_valid low
// FULL  | output stage holds a beat awaiting out_ready
module hs_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int SRC_W  = 2
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    output logic [N_REQ-1:0]        in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready,
    output logic [2:0]              beat_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [SRC_W-1:0]  grant;
    logic [DATA_W-1:0] sel_data;
    logic              found;
    logic              any_valid;
    logic              can_load;
    logic              load;
    logic              out_fire;
    int                idx;

    // Rotating priority search starting at ptr; first valid requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && in_valid[SRC_W'(idx)]) begin
                found = 1'b1;
                grant = SRC_W'(idx);
            end
        end
    end

    // Payload mux for the granted requester; only feeds the output register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == SRC_W'(i)) begin
                sel_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake qualifiers; reset blocks acceptance so nothing upstream is lost.
    always_comb begin
        any_valid = |in_valid;
        out_fire  = (state_q == FULL) && out_ready;
        can_load  = (state_q == EMPTY) || out_ready;
        load      = any_valid && can_load && !rst;
    end

    // One-hot ready back to the granted producer only.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            in_ready[i] = load && (grant == SRC_W'(i));
        end
    end

    // Next state, output-stage contents, pointer and beat counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = FULL;
            src_d   = grant;
            data_d  = sel_data;
            ptr_d   = (grant == SRC_W'(N_REQ - 1)) ? '0 : grant + SRC_W'(1);
        end else if (out_fire) begin
            state_d = EMPTY;
        end
        if (out_fire) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    // State registers with synchronous reset; a held beat is dropped uncounted.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign beat_cnt  = cnt_q;

endmodule
